// File: rtl/fp_wb_arbiter.sv
// Round-robin writeback arbiter feeding intermediate FP results into a 2-entry FIFO; ack-to-out_valid latency is 1 cycle.
// Backpressure: when the FIFO is full and its head is not popped this cycle, every in_ack stays low and sources hold.
module fp_wb_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ID_W      = 3,
  parameter int PAYLOAD_W = 96,
  localparam int SRC_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_done,
  input  logic [NUM_PORTS*ID_W-1:0]      in_id,
  input  logic [NUM_PORTS*PAYLOAD_W-1:0] in_payload,
  output logic [NUM_PORTS-1:0]           in_ack,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_id,
  output logic [PAYLOAD_W-1:0]           out_payload,
  output logic [SRC_W-1:0]               out_src
);

  logic [ID_W-1:0]      id_arr  [NUM_PORTS];
  logic [PAYLOAD_W-1:0] pay_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign id_arr[g]  = in_id[g*ID_W +: ID_W];
    assign pay_arr[g] = in_payload[g*PAYLOAD_W +: PAYLOAD_W];
  end

  logic [1:0]           count_q, count_d;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [SRC_W-1:0]     last_grant_q, last_grant_d;
  logic [ID_W-1:0]      id_q  [2];
  logic [PAYLOAD_W-1:0] pay_q [2];
  logic [SRC_W-1:0]     src_q [2];

  logic             pop;
  logic             space;
  logic             found;
  logic             push;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;

  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid & out_ready;
  assign space       = (count_q < 2'd2) | pop;
  assign out_id      = id_q[head_q];
  assign out_payload = pay_q[head_q];
  assign out_src     = src_q[head_q];

  // Search begins just after the last winner, so every waiting source is reached within NUM_PORTS-1 grants.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = SRC_W'((int'(last_grant_q) + k) % NUM_PORTS);
      if (!found && in_done[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Gating with rst keeps acks low while reset holds the FIFO empty.
  assign push = found & space & ~rst;

  always_comb begin
    in_ack = '0;
    if (push) in_ack[grant_idx] = 1'b1;
  end

  always_comb begin
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    last_grant_d = last_grant_q;
    if (push) begin
      tail_d       = ~tail_q;
      last_grant_d = grant_idx;
    end
    if (pop) head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      last_grant_q <= SRC_W'(NUM_PORTS - 1);
      for (int e = 0; e < 2; e++) begin
        id_q[e]  <= '0;
        pay_q[e] <= '0;
        src_q[e] <= '0;
      end
    end else begin
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      last_grant_q <= last_grant_d;
      if (push) begin
        id_q[tail_q]  <= id_arr[grant_idx];
        pay_q[tail_q] <= pay_arr[grant_idx];
        src_q[tail_q] <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_fp_wb_arbiter;
  localparam int NP = 2;
  localparam int IW = 3;
  localparam int PW = 96;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] pay;
    logic          src;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NP-1:0] in_done;
  logic [NP*IW-1:0] in_id;
  logic [NP*PW-1:0] in_payload;
  logic [NP-1:0] in_ack;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_id;
  logic [PW-1:0] out_payload;
  logic [0:0]    out_src;

  int n_checks = 0;
  int n_fail   = 0;

  fp_wb_arbiter #(.NUM_PORTS(NP), .ID_W(IW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .in_done(in_done), .in_id(in_id), .in_payload(in_payload),
    .in_ack(in_ack), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_payload(out_payload), .out_src(out_src)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] rnd_pay();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic set_src(input int i, input logic d, input logic [IW-1:0] id, input logic [PW-1:0] p);
    in_done[i] = d;
    in_id[i*IW +: IW] = id;
    in_payload[i*PW +: PW] = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_done = '0; out_ready = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    set_src(0, 1'b1, 3'd1, rnd_pay());
    set_src(1, 1'b1, 3'd2, rnd_pay());
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_checks++; if (in_ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", in_ack); end
    @(negedge clk); #1;
    n_checks++; if (out_id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0h want 0", out_id); end
    n_checks++; if (out_payload !== '0) begin n_fail++; $display("FAIL reset_payload: got %0h want 0", out_payload); end
    n_checks++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL reset_src: got %0h want 0", out_src); end
    @(negedge clk);
    in_done = '0; rst = 1'b0;
  endtask

  task automatic test_single();
    logic [PW-1:0] p;
    do_reset();
    p = rnd_pay();
    set_src(0, 1'b1, 3'd5, p);
    set_src(1, 1'b0, 3'd0, '0);
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b want 01", in_ack); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %0b want 0", out_valid); end
    @(negedge clk);
    in_done = '0; #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_checks++; if (out_id !== 3'd5) begin n_fail++; $display("FAIL single_id: got %0d want 5", out_id); end
    n_checks++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL single_src: got %0d want 0", out_src); end
    n_checks++; if (out_payload !== p) begin n_fail++; $display("FAIL single_payload: got %0h want %0h", out_payload, p); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_tie();
    logic [1:0] ack_tbl [4];
    ack_tbl = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    out_ready = 1'b1;
    set_src(0, 1'b1, 3'd1, rnd_pay());
    set_src(1, 1'b1, 3'd2, rnd_pay());
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (in_ack !== ack_tbl[c]) begin n_fail++; $display("FAIL tie_ack[%0d]: got %b want %b", c, in_ack, ack_tbl[c]); end
      n_checks++; if (out_valid !== (c > 0)) begin n_fail++; $display("FAIL tie_valid[%0d]: got %0b want %0b", c, out_valid, c > 0); end
      if (c > 0) begin
        n_checks++; if (out_src !== 1'((c - 1) % 2)) begin n_fail++; $display("FAIL tie_src[%0d]: got %0d want %0d", c, out_src, (c - 1) % 2); end
      end
      @(negedge clk);
    end
    in_done = '0; #1;
    n_checks++; if (out_src !== 1'b1) begin n_fail++; $display("FAIL tie_src_last: got %0d want 1", out_src); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [1:0] ack_tbl [4];
    ack_tbl = '{2'b01, 2'b10, 2'b00, 2'b00};
    do_reset();
    out_ready = 1'b0;
    set_src(0, 1'b1, 3'd1, rnd_pay());
    set_src(1, 1'b1, 3'd2, rnd_pay());
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (in_ack !== ack_tbl[c]) begin n_fail++; $display("FAIL bp_ack[%0d]: got %b want %b", c, in_ack, ack_tbl[c]); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (out_valid !== 1'b1 || out_id !== 3'd1) begin n_fail++; $display("FAIL bp_head: got v=%0b id=%0d want v=1 id=1", out_valid, out_id); end
    set_src(0, 1'b1, 3'd3, rnd_pay());
    out_ready = 1'b1; #1;
    n_checks++; if (in_ack !== 2'b01) begin n_fail++; $display("FAIL bp_resume_ack: got %b want 01", in_ack); end
    @(negedge clk);
    out_ready = 1'b0; in_done = '0;
  endtask

  task automatic test_full_pushpop();
    set_src(1, 1'b1, 3'd6, rnd_pay());
    set_src(0, 1'b0, 3'd0, '0);
    out_ready = 1'b1; #1;
    n_checks++; if (in_ack !== 2'b10) begin n_fail++; $display("FAIL full_ack: got %b want 10", in_ack); end
    n_checks++; if (out_id !== 3'd2 || out_src !== 1'b1) begin n_fail++; $display("FAIL full_head: got id=%0d src=%0d want id=2 src=1", out_id, out_src); end
    @(negedge clk);
    in_done = 2'b11; out_ready = 1'b0; #1;
    n_checks++; if (in_ack !== 2'b00) begin n_fail++; $display("FAIL full_still_full: got %b want 00", in_ack); end
    n_checks++; if (out_id !== 3'd3 || out_src !== 1'b0) begin n_fail++; $display("FAIL full_order0: got id=%0d src=%0d want id=3 src=0", out_id, out_src); end
    in_done = '0; out_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (out_id !== 3'd6 || out_src !== 1'b1) begin n_fail++; $display("FAIL full_order1: got id=%0d src=%0d want id=6 src=1", out_id, out_src); end
    @(negedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain: got %0b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_stability();
    logic [PW-1:0] p;
    do_reset();
    p = rnd_pay();
    out_ready = 1'b0;
    set_src(0, 1'b1, 3'd4, p);
    set_src(1, 1'b0, 3'd0, '0);
    #1;
    n_checks++; if (in_ack !== 2'b01) begin n_fail++; $display("FAIL stab_ack: got %b want 01", in_ack); end
    @(negedge clk);
    set_src(0, 1'b0, 3'd0, '0);
    set_src(1, 1'b1, 3'd7, rnd_pay());
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_id !== 3'd4 || out_src !== 1'b0) begin n_fail++; $display("FAIL stab_head[%0d]: got v=%0b id=%0d src=%0d want v=1 id=4 src=0", c, out_valid, out_id, out_src); end
      n_checks++; if (out_payload !== p) begin n_fail++; $display("FAIL stab_payload[%0d]: got %0h want %0h", c, out_payload, p); end
      @(negedge clk);
    end
    in_done = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    set_src(0, 1'b1, 3'd1, rnd_pay());
    set_src(1, 1'b1, 3'd2, rnd_pay());
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: got %0b want 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_async: got %0b want 0", out_valid); end
    n_checks++; if (in_ack !== 2'b00) begin n_fail++; $display("FAIL mid_ack_in_reset: got %b want 00", in_ack); end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    set_src(0, 1'b1, 3'd5, rnd_pay());
    set_src(1, 1'b1, 3'd6, rnd_pay());
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got %0b want 0", out_valid); end
    n_checks++; if (in_ack !== 2'b01) begin n_fail++; $display("FAIL mid_first_tie: got %b want 01", in_ack); end
    @(negedge clk);
    in_done = '0; #1;
    n_checks++; if (out_valid !== 1'b1 || out_id !== 3'd5) begin n_fail++; $display("FAIL mid_after: got v=%0b id=%0d want v=1 id=5", out_valid, out_id); end
    @(negedge clk);
  endtask

  task automatic test_random();
    ent_t          q[$];
    ent_t          e;
    int            lg;
    int            g;
    int            waitg [NP];
    logic [NP-1:0] hold;
    logic [IW-1:0] hid [NP];
    logic [PW-1:0] hp [NP];
    logic [NP-1:0] eack;
    logic          ev;
    logic          pop;
    logic          space;
    do_reset();
    lg = NP - 1;
    hold = '0;
    for (int i = 0; i < NP; i++) begin waitg[i] = 0; hid[i] = '0; hp[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (!hold[i] && $urandom_range(0, 2) != 0) begin
          hold[i] = 1'b1; hid[i] = IW'($urandom); hp[i] = rnd_pay();
        end
        set_src(i, hold[i], hid[i], hp[i]);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ev    = (q.size() != 0);
      pop   = ev && out_ready;
      space = (q.size() < 2) || pop;
      g = -1;
      if (space)
        for (int k = 1; k <= NP; k++)
          if (g < 0 && hold[(lg + k) % NP]) g = (lg + k) % NP;
      eack = '0;
      if (g >= 0) eack[g] = 1'b1;
      n_checks++; if (in_ack !== eack) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b want %b", cyc, in_ack, eack); end
      n_checks++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", cyc, out_valid, ev); end
      if (ev) begin
        n_checks++;
        if (out_id !== q[0].id || out_payload !== q[0].pay || out_src !== q[0].src) begin
          n_fail++;
          $display("FAIL rnd_head@%0d: got id=%0d src=%0d pay=%0h want id=%0d src=%0d pay=%0h",
                   cyc, out_id, out_src, out_payload, q[0].id, q[0].src, q[0].pay);
        end
      end
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
        for (int i = 0; i < NP; i++) begin
          if (i != g && hold[i]) begin
            waitg[i]++;
            n_checks++; if (waitg[i] > NP - 1) begin n_fail++; $display("FAIL rnd_fair@%0d: src %0d waited %0d grants, limit %0d", cyc, i, waitg[i], NP - 1); end
          end
        end
        waitg[g] = 0;
        e.id = hid[g]; e.pay = hp[g]; e.src = 1'(g);
        q.push_back(e);
        lg = g;
        if ($urandom_range(0, 1) != 0) begin
          hid[g] = IW'($urandom); hp[g] = rnd_pay();
        end else begin
          hold[g] = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_done = '0; out_ready = 1'b0;
  endtask

  initial begin
    in_done = '0;
    in_id = '0;
    in_payload = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_full_pushpop();
    test_stability();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
